// File: rtl/rvm_adder_seq.sv
// Multi-cycle add/sub/compare unit: WIDTH-bit operands, CHUNK bits per cycle, registered carry chain.
// Optional build macro RVM_ADDER_ZERO_SKIP_EN: ADD/SUB with rhs == 0 finishes one cycle after accept.
module rvm_adder_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  output logic             ready,
  output logic             done,
  output logic [WIDTH:0]   result,
  output logic             overflow
);

  localparam int NCH = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("rvm_adder_seq: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_SLT  = 3'b011,
    OP_SLTU = 3'b100
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] lhs_q, lhs_d;   // lhs shifts out as the sum shifts in
  logic [WIDTH-1:0] rhs_q, rhs_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH:0]   result_q, result_d;
  logic             overflow_q, overflow_d;
`ifdef RVM_ADDER_ZERO_SKIP_EN
  logic             skip_q, skip_d;
`endif

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] lhs_shift, rhs_shift;
  logic             op_valid, op_is_sub, accept;
  logic             fin_carry, fin_msb, fin_ovf;

  assign chunk_sum = {1'b0, lhs_q[CHUNK-1:0]} + {1'b0, rhs_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};

  if (CHUNK < WIDTH) begin : g_multi
    assign lhs_shift = {chunk_sum[CHUNK-1:0], lhs_q[WIDTH-1:CHUNK]};
    assign rhs_shift = {{CHUNK{1'b0}}, rhs_q[WIDTH-1:CHUNK]};
  end else begin : g_single
    assign lhs_shift = chunk_sum[CHUNK-1:0];
    assign rhs_shift = '0;
  end

  assign fin_carry = chunk_sum[CHUNK];
  assign fin_msb   = lhs_shift[WIDTH-1];
  assign fin_ovf   = (a_msb_q == b_msb_q) && (fin_msb != a_msb_q);

  assign op_valid  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
  assign op_is_sub = (op != OP_ADD);
  assign ready     = (state_q != S_RUN);
  assign accept    = req && ready && op_valid;

  always_comb begin
    // NOTE: every *_d starts from its *_q so no path through this block can infer a latch.
    state_d    = state_q;
    op_d       = op_q;
    lhs_d      = lhs_q;
    rhs_d      = rhs_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    result_d   = result_q;
    overflow_d = overflow_q;
`ifdef RVM_ADDER_ZERO_SKIP_EN
    skip_d     = skip_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = S_RUN;
          op_d    = op_e'(op);
          lhs_d   = lhs;
          rhs_d   = op_is_sub ? ~rhs : rhs;
          carry_d = op_is_sub;
          cnt_d   = '0;
          a_msb_d = lhs[WIDTH-1];
          b_msb_d = op_is_sub ? ~rhs[WIDTH-1] : rhs[WIDTH-1];
`ifdef RVM_ADDER_ZERO_SKIP_EN
          skip_d  = ((op == OP_ADD) || (op == OP_SUB)) && (rhs == '0);
`endif
        end
      end
      S_RUN: begin
        lhs_d   = lhs_shift;
        rhs_d   = rhs_shift;
        carry_d = fin_carry;
        cnt_d   = cnt_q + CW'(1);
`ifdef RVM_ADDER_ZERO_SKIP_EN
        if (skip_q) begin
          state_d    = S_DONE;
          result_d   = {1'b0, lhs_q};
          overflow_d = 1'b0;
        end else
`endif
        if (cnt_q == CW'(NCH - 1)) begin
          state_d = S_DONE;
          case (op_q)
            OP_ADD: begin
              result_d   = {fin_carry, lhs_shift};
              overflow_d = fin_ovf;
            end
            OP_SUB: begin
              result_d   = {~fin_carry, lhs_shift};
              overflow_d = fin_ovf;
            end
            OP_SLT: begin
              result_d   = {{WIDTH{1'b0}}, fin_msb ^ fin_ovf};
              overflow_d = 1'b0;
            end
            OP_SLTU: begin
              result_d   = {{WIDTH{1'b0}}, ~fin_carry};
              overflow_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so all flops see pre-edge values; datapath regs are reset too so reset leaves result/overflow at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NOP;
      lhs_q      <= '0;
      rhs_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
`ifdef RVM_ADDER_ZERO_SKIP_EN
      skip_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      lhs_q      <= lhs_d;
      rhs_q      <= rhs_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      a_msb_q    <= a_msb_d;
      b_msb_q    <= b_msb_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
`ifdef RVM_ADDER_ZERO_SKIP_EN
      skip_q     <= skip_d;
`endif
    end
  end

  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_rvm_adder_seq.sv
// Self-checking bench for rvm_adder_seq (WIDTH=32, CHUNK=8): vector table, corner sequences, random ops vs a model.
module tb_rvm_adder_seq;

  localparam int NCH = 4;

  logic        clk;
  logic        reset;
  logic        req;
  logic [2:0]  op;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic        ready;
  logic        done;
  logic [32:0] result;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [32:0] last_res;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] res;
    logic        ovf;
  } vec_t;
  vec_t vecs[$];

  rvm_adder_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .lhs(lhs), .rhs(rhs),
    .ready(ready), .done(done), .result(result), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands, returns {overflow, result}.
  function automatic logic [33:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    logic [32:0] r;
    logic        v;
    sa = $signed(a);
    sb = $signed(b);
    r = '0;
    v = 1'b0;
    case (o)
      3'd1: begin r = {1'b0, a} + {1'b0, b}; s = sa + sb; v = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000); end
      3'd2: begin r = {1'b0, a} - {1'b0, b}; s = sa - sb; v = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000); end
      3'd3: r = {32'd0, sa < sb};
      3'd4: r = {32'd0, a < b};
      default: ;
    endcase
    return {v, r};
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] b);
`ifdef RVM_ADDER_ZERO_SKIP_EN
    if ((o == 3'd1 || o == 3'd2) && b == 32'd0) return 1;
`endif
    return NCH;
  endfunction

  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [32:0] exp_res, input logic exp_ovf);
    int lat;
    bit held_ok;
    @(negedge clk);
    for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
    req = 1'b1; op = o; lhs = a; rhs = b;
    @(posedge clk);
    #1;
    req = 1'b0; op = 3'($urandom_range(1, 4)); lhs = $urandom; rhs = $urandom;
    held_ok = 1'b1;
    for (lat = 1; lat <= 40; lat++) begin
      @(posedge clk);
      #1;
      if (done) break;
      if (result !== last_res) held_ok = 1'b0;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat(o, b)));
    check({tag, " hold"}, 64'(held_ok), 64'd1);
    check({tag, " result"}, 64'(result), 64'(exp_res));
    check({tag, " overflow"}, 64'(overflow), 64'(exp_ovf));
    last_res = exp_res;
    @(posedge clk);
    #1;
    check({tag, " done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [33:0] m;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          t;
    bit          seen;

    reset = 1'b1; req = 1'b0; op = 3'd0; lhs = '0; rhs = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset ready", 64'(ready), 64'd1);
    check("reset done", 64'(done), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    last_res = '0;

    vecs.push_back('{3'd1, 32'hFFFFFFFF, 32'h00000001, 33'h1_00000000, 1'b0});
    vecs.push_back('{3'd2, 32'h80000000, 32'h00000001, 33'h0_7FFFFFFF, 1'b1});
    vecs.push_back('{3'd2, 32'h00000000, 32'h00000001, 33'h1_FFFFFFFF, 1'b0});
    vecs.push_back('{3'd3, 32'hFFFFFFFF, 32'h00000001, 33'h0_00000001, 1'b0});
    vecs.push_back('{3'd4, 32'hFFFFFFFF, 32'h00000001, 33'h0_00000000, 1'b0});
    vecs.push_back('{3'd3, 32'h7FFFFFFF, 32'h80000000, 33'h0_00000000, 1'b0});
    vecs.push_back('{3'd1, 32'h7FFFFFFF, 32'h00000001, 33'h0_80000000, 1'b1});
    vecs.push_back('{3'd1, 32'h80000000, 32'h80000000, 33'h1_00000000, 1'b1});
    vecs.push_back('{3'd4, 32'h00000001, 32'hFFFFFFFF, 33'h0_00000001, 1'b0});
    vecs.push_back('{3'd2, 32'h00000005, 32'h00000005, 33'h0_00000000, 1'b0});
    vecs.push_back('{3'd1, 32'h000000FF, 32'h00000001, 33'h0_00000100, 1'b0});
    vecs.push_back('{3'd1, 32'h00001234, 32'h00000000, 33'h0_00001234, 1'b0});
    vecs.push_back('{3'd2, 32'h00001234, 32'h00000000, 33'h0_00001234, 1'b0});
    foreach (vecs[i]) do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf);

    // Reset during the second RUN cycle discards the op.
    @(negedge clk);
    req = 1'b1; op = 3'd1; lhs = 32'd10; rhs = 32'd20;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midreset ready", 64'(ready), 64'd1);
    check("midreset done", 64'(done), 64'd0);
    check("midreset result", 64'(result), 64'd0);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check("midreset no_done", 64'(seen), 64'd0);
    last_res = '0;
    do_op("after_reset", 3'd1, 32'd3, 32'd4, 33'd7, 1'b0);

    // Back-to-back: SUB accepted in the DONE cycle of an ADD.
    @(negedge clk);
    req = 1'b1; op = 3'd1; lhs = 32'd1; rhs = 32'd2;
    @(posedge clk);
    #1;
    for (t = 0; t < 40 && !done; t++) begin
      @(posedge clk);
      #1;
    end
    check("b2b first_done", 64'(done), 64'd1);
    check("b2b first_result", 64'(result), 64'h0_00000003);
    check("b2b ready_in_done", 64'(ready), 64'd1);
    op = 3'd2; lhs = 32'd5; rhs = 32'd7;
    @(posedge clk);
    #1;
    req = 1'b0;
    for (t = 1; t <= 40 && !done; t++) begin
      @(posedge clk);
      #1;
    end
    check("b2b spacing", 64'(t), 64'(NCH + 1));
    check("b2b second_result", 64'(result), 64'h1_FFFFFFFE);
    check("b2b second_overflow", 64'(overflow), 64'd0);
    last_res = 33'h1_FFFFFFFE;

    // NOP and reserved ops are ignored.
    @(negedge clk);
    seen = 1'b0;
    t = 0;
    req = 1'b1; op = 3'd0; lhs = 32'd9; rhs = 32'd9;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
      if (!ready) t++;
      op = 3'd6;
    end
    req = 1'b0;
    check("nop no_done", 64'(seen), 64'd0);
    check("nop ready", 64'(t), 64'd0);
    check("nop hold", 64'(result), 64'(last_res));

    // Random operations against the model.
    for (int n = 0; n < 150; n++) begin
      ro = 3'($urandom_range(1, 4));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = ra;
        2:       rb = 32'h80000000;
        default: rb = $urandom;
      endcase
      m = model(ro, ra, rb);
      do_op($sformatf("rnd%0d", n), ro, ra, rb, m[32:0], m[33]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvm_adder_seq.md
Name: rvm_adder_seq

Overview:
Parametrised, multi-cycle successor to the single-cycle 32-bit add/subtract unit. It processes WIDTH-bit operands CHUNK bits per cycle through a registered carry chain, so a narrow adder is reused across cycles. It adds a req/ready/done handshake, signed-overflow detection and signed/unsigned set-less-than modes. It sits in the multi-cycle core's execute stage, driven by the control FSM.

Parameters:
WIDTH, 32, operand width in bits; must be ≥ 1.
CHUNK, 8, bits processed per cycle; WIDTH % CHUNK != 0 is an elaboration error. NCH = WIDTH/CHUNK.

Ports:
clk  input  1  core clock; all state updates on rising edge.
reset  input  1  synchronous reset, active high.
req  input  1  operation request; sampled with ready.
op  input  3  000 NOP, 001 ADD, 010 SUB, 011 SLT (signed), 100 SLTU (unsigned); 101-111 reserved.
lhs  input  WIDTH  left operand.
rhs  input  WIDTH  right operand.
ready  output  1  unit can accept a request this cycle.
done  output  1  one-cycle pulse; result/overflow valid.
result  output  WIDTH+1  ADD: {carry, sum}. SUB: {borrow, difference}. SLT/SLTU: bit 0 = less-than, all others 0.
overflow  output  1  signed overflow for ADD/SUB; 0 for compares.

Behaviour:
- Single clock (clk), synchronous active-high reset (reset); no other clock or reset.
- Reset:
  - state = IDLE, ready = 1, done = 0, result = 0, overflow = 0, internal carry and chunk counter = 0.
- Accept:
  - Occurs on a clock edge where req & ready and op ∈ {ADD, SUB, SLT, SLTU}.
  - lhs, rhs and op are latched at accept; later input changes have no effect.
  - req with NOP or a reserved op is ignored: no state change, no done.
- States:
  - IDLE: ready = 1; accept → RUN.
  - RUN: ready = 0; one chunk per edge, LSB chunk first; req is ignored. After chunk NCH-1 → DONE.
  - DONE: done = 1, ready = 1, for exactly one cycle. Accept → RUN (back-to-back); otherwise → IDLE.
- Latency:
  - Accept at edge E0.
  - Chunk k is computed at edge E(k+1).
  - done is high during the cycle after edge E(NCH), i.e. NCH cycles after acceptance.
  - Throughput: one operation per NCH+1 cycles.
- Arithmetic:
  - SUB, SLT and SLTU use the inverted rhs with initial carry-in 1; ADD uses initial carry-in 0.
  - ADD: result[WIDTH] = final carry-out.
  - SUB: result[WIDTH] = NOT final carry-out (borrow), so result equals the (WIDTH+1)-bit value {0,lhs} - {0,rhs}.
  - Overflow (ADD/SUB): operand MSBs (rhs inverted for SUB) are equal and differ from the sum MSB.
  - SLTU: less-than = borrow.
  - SLT: less-than = diff_msb XOR signed_overflow.
- Output holding:
  - result and overflow update only at the edge entering DONE.
  - They hold their values through IDLE until the next completion; the previous result is held during RUN.
- Boundaries:
  - CHUNK = WIDTH gives a single RUN cycle.
  - Results wrap modulo 2^WIDTH in the low bits, with carry/borrow carried in the top bit.
- Reset mid-operation: return to IDLE with the reset values above. The in-flight op is discarded, and no done is issued for it.

Optional Feature:
RVM_ADDER_ZERO_SKIP_EN
- Defined: an accepted ADD or SUB with rhs == 0 skips RUN and goes straight to DONE at the next edge (done 1 cycle after accept). Result = {0, lhs}, overflow = 0. Other ops are unaffected.
- Undefined: every op takes the full NCH-cycle latency. Results are identical in both builds; only timing differs.

Test Plan:
- WIDTH=32, CHUNK=8, ADD 0xFFFFFFFF + 0x00000001 → done 4 cycles after accept, result = 0x1_00000000, overflow = 0.
- SUB 0x80000000 - 0x00000001 → result = 0x0_7FFFFFFF, overflow = 1. SUB 0x00000000 - 0x00000001 → result = 0x1_FFFFFFFF, overflow = 0.
- SLT lhs = 0xFFFFFFFF, rhs = 0x00000001 → result = 1. SLTU with the same operands → result = 0. SLT 0x7FFFFFFF vs 0x80000000 → result = 0.
- Accept ADD, assert reset on the 2nd RUN cycle → no done, ready = 1 and result = 0 the cycle after reset; a new ADD 3 + 4 then gives result = 7.
- Back-to-back: req held with ADD 1 + 2, then SUB 5 - 7 accepted in the DONE cycle → two done pulses 5 cycles apart, results 0x0_00000003 and 0x1_FFFFFFFE.
- req with op = 000 or 110 in IDLE → no state change, done never asserts. With RVM_ADDER_ZERO_SKIP_EN defined, ADD 0x1234 + 0 → done 1 cycle after accept, result = 0x1234.
